sv_bus_mux_demux_demux: RTL

SV_BUS_MUX_DEMUX_DEMUX -- requirements
Module: sv_bus_mux_demux_demux

---
 rtl/sv_bus_mux_demux_demux.sv | 115 +++++++++++
 1 files changed

// File: rtl/sv_bus_mux_demux_demux.sv
// ---------------------------------------------------------------------------
// sv_bus_mux_demux_demux
//
// Reassembles a byte stream into 64-bit bus transfers. Every 8 accepted
// stream bytes form one packet: bytes 0..3 become bus_dat (little-endian),
// bytes 4..7 become bus_adr (little-endian). Bytes 0..6 collect in an
// assembly register. The 8th byte loads the registered bus output together
// with the assembled bytes.
//
// Parameters
//   BUF      1: double buffered. The next packet assembles while the output
//               waits. Only its last byte stalls.
//            0: single buffered. The stream stalls while the output is full.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   synchronous reset, active low
//   str_vld  in   1   stream byte valid
//   str_bus  in   8   stream byte
//   str_rdy  out  1   stream byte ready (combinational from regs/bus_rdy/rst)
//   bus_vld  out  1   bus transfer valid (registered)
//   bus_adr  out  32  reassembled address (registered)
//   bus_dat  out  32  reassembled data (registered)
//   bus_rdy  in   1   bus ready / acknowledge
// ---------------------------------------------------------------------------
module sv_bus_mux_demux_demux #(
  parameter int unsigned BUF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        str_vld,
  input  logic [7:0]  str_bus,
  output logic        str_rdy,
  output logic        bus_vld,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat,
  input  logic        bus_rdy
);

  logic [2:0]  cnt_q, cnt_d;
  logic [55:0] asm_q, asm_d;
  logic        vld_q, vld_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;

  logic        rdy_raw;
  logic        str_trn;
  logic        bus_trn;
  logic        pkt_load;

  // Double buffering only has to stall the last byte. That byte would need
  // the output register, which is still waiting on the bus. A bus_rdy in
  // the same cycle frees the output register, so the last byte goes through
  // without a bubble.
  generate
    if (BUF != 0) begin : g_dbl
      assign rdy_raw = !((cnt_q == 3'd7) && vld_q && !bus_rdy);
    end else begin : g_sgl
      assign rdy_raw = !vld_q;
    end
  endgenerate

  assign str_rdy  = rst & rdy_raw;
  assign str_trn  = str_vld & str_rdy;
  assign bus_trn  = vld_q & bus_rdy;
  assign pkt_load = str_trn & (cnt_q == 3'd7);

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    vld_d = vld_q;
    adr_d = adr_q;
    dat_d = dat_q;

    if (str_trn) begin
      cnt_d = cnt_q + 3'd1;
      for (int k = 0; k < 7; k++) begin
        if (cnt_q == 3'(k)) begin
          asm_d[8*k +: 8] = str_bus;
        end
      end
    end

    // A packet load takes priority over the bus clearing valid. A transfer
    // on the same edge hands the old word over, and the new word replaces it.
    if (pkt_load) begin
      vld_d = 1'b1;
      adr_d = {str_bus, asm_q[55:32]};
      dat_d = asm_q[31:0];
    end else if (bus_trn) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 3'd0;
      asm_q <= 56'd0;
      vld_q <= 1'b0;
      adr_q <= 32'd0;
      dat_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      vld_q <= vld_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign bus_vld = vld_q;
  assign bus_adr = adr_q;
  assign bus_dat = dat_q;

endmodule
